// File: rtl/osc_pkg.sv
// Shared sizing defaults, mix-width derivation and sequencer state encoding
// for the time-multiplexed oscillator block.
package osc_pkg;
  localparam int NUM_VOICES_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;

  // Mix must hold NUM_VOICES full-scale samples without wrapping.
  function automatic int mix_width(input int nv, input int aw);
    return aw + $clog2(nv);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
endpackage

// File: rtl/voice_sequencer_if.sv
// Voice configuration write channel (valid/ready) into the sequencer.
interface voice_sequencer_if import osc_pkg::*; #(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
);
  logic                          cfg_valid_in;
  logic                          cfg_ready_out;
  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_in;
  logic [ACC_WIDTH-1:0]          cfg_incr_in;
  logic                          cfg_enable_in;
  logic                          cfg_phase_clr_in;

  modport master (
    output cfg_valid_in, cfg_voice_in, cfg_incr_in, cfg_enable_in, cfg_phase_clr_in,
    input  cfg_ready_out
  );
  modport slave (
    input  cfg_valid_in, cfg_voice_in, cfg_incr_in, cfg_enable_in, cfg_phase_clr_in,
    output cfg_ready_out
  );
endinterface

// File: rtl/voice_sequencer_tri_shaper.sv
// Phase-to-triangle shaper: fold on the phase MSB, double, then bias to signed.
module tri_shaper #(
  parameter int ACC_WIDTH = 32
)(
  input  logic [ACC_WIDTH-1:0]        phase,
  output logic signed [ACC_WIDTH-1:0] sample
);
  logic [ACC_WIDTH-2:0] fold;

  assign fold = phase[ACC_WIDTH-1] ? ~phase[ACC_WIDTH-2:0] : phase[ACC_WIDTH-2:0];
  // {fold,0} with its top bit inverted recentres the 0..max ramp around zero.
  assign sample = {~fold[ACC_WIDTH-2], fold[ACC_WIDTH-3:0], 1'b0};
endmodule

// File: rtl/voice_sequencer.sv
// Time-multiplexed triangle oscillator bank: one step_in runs every voice
// through a single shared shaper, one voice per cycle, then emits the mix.
module voice_sequencer import osc_pkg::*; #(
  parameter int  NUM_VOICES = NUM_VOICES_DEF,
  parameter int  ACC_WIDTH  = ACC_WIDTH_DEF,
  localparam int VW         = $clog2(NUM_VOICES),
  localparam int MIX_WIDTH  = mix_width(NUM_VOICES, ACC_WIDTH)
)(
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        step_in,
  voice_sequencer_if.slave            cfg,
  output logic signed [ACC_WIDTH-1:0] sample_out,
  output logic                        sample_valid_out,
  output logic [VW-1:0]               voice_id_out,
  output logic signed [MIX_WIDTH-1:0] mix_out,
  output logic                        mix_valid_out,
  output logic                        busy_out,
  output logic                        overrun_out
);
  seq_state_e state_q, state_d;
  logic [VW-1:0]                             idx_q;
  logic [NUM_VOICES-1:0][ACC_WIDTH-1:0]      phase_q, incr_q;
  logic [NUM_VOICES-1:0]                     en_q;
  logic signed [MIX_WIDTH-1:0]               acc_q;
  logic signed [ACC_WIDTH-1:0]               shaped, voice_sample;
  logic                                      cfg_fire, step_start;

  assign cfg.cfg_ready_out = (state_q == IDLE);
  assign cfg_fire          = cfg.cfg_valid_in & cfg.cfg_ready_out;
  assign step_start        = step_in & (state_q == IDLE);
  assign busy_out          = (state_q != IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_in) state_d = RUN;
      RUN:     if (idx_q == VW'(NUM_VOICES-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  tri_shaper #(.ACC_WIDTH(ACC_WIDTH)) u_shaper (
    .phase  (phase_q[idx_q]),
    .sample (shaped)
  );

  assign voice_sample = en_q[idx_q] ? shaped : '0;

  // Config only fires in IDLE and phase advance only in RUN, so the two
  // writers of phase_q never collide.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase_q <= '0;
      incr_q  <= '0;
      en_q    <= '0;
    end else begin
      if (cfg_fire) begin
        incr_q[cfg.cfg_voice_in] <= cfg.cfg_incr_in;
        en_q[cfg.cfg_voice_in]   <= cfg.cfg_enable_in;
        if (cfg.cfg_phase_clr_in) phase_q[cfg.cfg_voice_in] <= '0;
      end
      if (state_q == RUN && en_q[idx_q])
        phase_q[idx_q] <= phase_q[idx_q] + incr_q[idx_q];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q            <= '0;
      acc_q            <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      voice_id_out     <= '0;
      mix_out          <= '0;
      mix_valid_out    <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      idx_q            <= (state_q == RUN) ? idx_q + VW'(1) : '0;
      sample_valid_out <= (state_q == RUN);
      mix_valid_out    <= (state_q == DONE);
      if (step_start)
        acc_q <= '0;
      else if (state_q == RUN)
        acc_q <= acc_q + {{VW{voice_sample[ACC_WIDTH-1]}}, voice_sample};
      if (state_q == RUN) begin
        sample_out   <= voice_sample;
        voice_id_out <= idx_q;
      end
      if (state_q == DONE) mix_out <= acc_q;
      if (step_in && state_q != IDLE) overrun_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_voice_sequencer.sv
// Self-checking bench for voice_sequencer: table vectors, corner sequences
// and randomized passes against a behavioural oscillator-bank model.
module tb_voice_sequencer;
  localparam int NV = 8;
  localparam int AW = 32;
  localparam int VW = $clog2(NV);
  localparam int MW = AW + VW;
  localparam longint unsigned MASK = (64'd1 << AW) - 1;
  typedef logic signed [63:0] val_t;
  localparam val_t NEG_HALF = -(64'sd1 <<< (AW-1));

  logic clk_in = 1'b0, rst_in = 1'b0, step_in = 1'b0;
  logic signed [AW-1:0] sample_out;
  logic                 sample_valid_out;
  logic [VW-1:0]        voice_id_out;
  logic signed [MW-1:0] mix_out;
  logic                 mix_valid_out, busy_out, overrun_out;

  voice_sequencer_if #(.NUM_VOICES(NV), .ACC_WIDTH(AW)) cfg_if();

  voice_sequencer #(.NUM_VOICES(NV), .ACC_WIDTH(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .cfg(cfg_if),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .voice_id_out(voice_id_out), .mix_out(mix_out),
    .mix_valid_out(mix_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input val_t act, input val_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: triangle as plain arithmetic on the phase value.
  longint unsigned m_phase[NV], m_incr[NV];
  bit              m_en[NV];
  val_t            exp_s[NV], got_s[NV];
  val_t            exp_mix;

  function automatic val_t tri_ref(input longint unsigned p);
    longint half = longint'(64'd1 << (AW-1));
    longint sp   = longint'(p);
    if (sp < half) return val_t'(2*sp - half);
    return val_t'(2*(2*half - 1 - sp) - half);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = 0; m_incr[v] = 0; m_en[v] = 0;
    end
  endtask

  task automatic model_cfg(input int v, input longint unsigned incr, input bit en, input bit clr);
    m_incr[v] = incr & MASK;
    m_en[v]   = en;
    if (clr) m_phase[v] = 0;
  endtask

  task automatic model_pass();
    exp_mix = 0;
    for (int v = 0; v < NV; v++) begin
      exp_s[v] = m_en[v] ? tri_ref(m_phase[v]) : 0;
      exp_mix += exp_s[v];
      if (m_en[v]) m_phase[v] = (m_phase[v] + m_incr[v]) & MASK;
    end
  endtask

  task automatic set_cfg(input bit vld, input int v, input longint unsigned incr,
                         input bit en, input bit clr);
    cfg_if.cfg_valid_in     = vld;
    cfg_if.cfg_voice_in     = VW'(v);
    cfg_if.cfg_incr_in      = AW'(incr);
    cfg_if.cfg_enable_in    = en;
    cfg_if.cfg_phase_clr_in = clr;
  endtask

  task automatic cfg_write(input int v, input longint unsigned incr, input bit en, input bit clr);
    set_cfg(1'b1, v, incr, en, clr);
    @(posedge clk_in); #1;
    cfg_if.cfg_valid_in = 1'b0;
    model_cfg(v, incr, en, clr);
  endtask

  // One full pass from IDLE, optionally with a config write on the step edge.
  task automatic run_pass(input bit do_cfg, input int v, input longint unsigned incr,
                          input bit en, input bit clr);
    if (do_cfg) begin
      set_cfg(1'b1, v, incr, en, clr);
      model_cfg(v, incr, en, clr);
    end
    model_pass();
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    cfg_if.cfg_valid_in = 1'b0;
    chk("busy_in_pass", busy_out, 1);
    for (int k = 0; k < NV; k++) begin
      @(posedge clk_in); #1;
      chk("sample_valid", sample_valid_out, 1);
      chk("voice_id", voice_id_out, k);
      chk("sample", $signed(sample_out), exp_s[k]);
      got_s[k] = $signed(sample_out);
      if (k == NV-1) chk("mix_valid_early", mix_valid_out, 0);
    end
    @(posedge clk_in); #1;
    chk("mix_valid", mix_valid_out, 1);
    chk("mix", $signed(mix_out), exp_mix);
    chk("sample_valid_off", sample_valid_out, 0);
    chk("sample_hold", $signed(sample_out), exp_s[NV-1]);
    @(posedge clk_in); #1;
    chk("mix_valid_pulse", mix_valid_out, 0);
    chk("mix_hold", $signed(mix_out), exp_mix);
    chk("ready_idle", cfg_if.cfg_ready_out, 1);
  endtask

  typedef struct {
    int              voice;
    longint unsigned incr;
    bit              en;
    bit              clr;
    val_t            exp_v0;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, waited;
    set_cfg(1'b0, 0, 0, 1'b0, 1'b0);
    model_reset();

    #12;
    chk("rst_sample", $signed(sample_out), 0);
    chk("rst_sample_valid", sample_valid_out, 0);
    chk("rst_voice_id", voice_id_out, 0);
    chk("rst_mix", $signed(mix_out), 0);
    chk("rst_mix_valid", mix_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_overrun", overrun_out, 0);
    chk("rst_ready", cfg_if.cfg_ready_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Quarter-cycle ramp on voice 0; config rewritten on each step edge.
    tbl[0] = '{0, 64'h40000000, 1'b1, 1'b1, NEG_HALF};
    tbl[1] = '{0, 64'h40000000, 1'b1, 1'b0, 0};
    tbl[2] = '{0, 64'h40000000, 1'b1, 1'b0, 64'sh7FFFFFFE};
    tbl[3] = '{0, 64'h40000000, 1'b1, 1'b0, -64'sd2};
    tbl[4] = '{0, 64'h40000000, 1'b1, 1'b0, NEG_HALF};
    for (int i = 0; i < 5; i++) begin
      run_pass(1'b1, tbl[i].voice, tbl[i].incr, tbl[i].en, tbl[i].clr);
      chk("tbl_v0", got_s[0], tbl[i].exp_v0);
      for (int v = 1; v < NV; v++) chk("tbl_off_voice", got_s[v], 0);
    end

    // Two full-negative voices: most negative mix, 9 cycles after step.
    cfg_write(0, 0, 1'b1, 1'b1);
    cfg_write(1, 0, 1'b1, 1'b1);
    run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    chk("mix_neg_2p32", $signed(mix_out), -(64'sd1 <<< 32));
    chk("overrun_clear", overrun_out, 0);

    // Second step 3 cycles into the pass is dropped, flagged and sticky.
    model_pass();
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    chk("overrun_set", overrun_out, 1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_in); #1;
      if (mix_valid_out) pulses++;
    end
    chk("overrun_one_mix", pulses, 1);
    chk("overrun_mix", $signed(mix_out), exp_mix);
    chk("overrun_sticky", overrun_out, 1);

    // Config held through a pass waits for IDLE, then lands.
    model_pass();
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    set_cfg(1'b1, 2, 64'h10000000, 1'b1, 1'b1);
    waited = 0;
    for (int c = 0; c < 20; c++) begin
      if (cfg_if.cfg_ready_out) break;
      @(posedge clk_in); #1;
      waited++;
    end
    chk("ready_low_cycles", waited, NV+1);
    chk("busy_done", busy_out, 0);
    @(posedge clk_in); #1;
    cfg_if.cfg_valid_in = 1'b0;
    model_cfg(2, 64'h10000000, 1'b1, 1'b1);
    run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    chk("late_write_v2", got_s[2], NEG_HALF);

    // Write on the step edge enables voice 3 for this very pass; then wraps.
    run_pass(1'b1, 3, 64'hFFFFFFFF, 1'b1, 1'b1);
    chk("same_edge_v3", got_s[3], NEG_HALF);
    run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    chk("wrap_v3_p1", got_s[3], NEG_HALF);
    run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    chk("wrap_v3_p2", got_s[3], NEG_HALF + 2);

    // Reset while voice 4 is being processed.
    model_pass();
    step_in = 1'b1;
    @(posedge clk_in); #1;
    step_in = 1'b0;
    repeat (4) begin @(posedge clk_in); #1; end
    rst_in = 1'b0;
    #1;
    chk("midrst_sample", $signed(sample_out), 0);
    chk("midrst_valid", sample_valid_out, 0);
    chk("midrst_voice", voice_id_out, 0);
    chk("midrst_mix", $signed(mix_out), 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_overrun", overrun_out, 0);
    chk("midrst_ready", cfg_if.cfg_ready_out, 1);
    model_reset();
    repeat (2) begin @(posedge clk_in); #1; end
    rst_in = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_in); #1;
      if (mix_valid_out) pulses++;
    end
    chk("midrst_no_mix", pulses, 0);
    run_pass(1'b1, 0, 64'h40000000, 1'b1, 1'b0);
    chk("post_rst_v0", got_s[0], NEG_HALF);

    // Randomized config traffic and passes.
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, NV-1)), longint'($urandom) & MASK,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_pass(1'($urandom_range(0, 1)), int'($urandom_range(0, NV-1)),
               longint'($urandom) & MASK, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
